// File: rtl/m1e_pkg.sv
// m1e_pkg: state type, SRAM plane bases and colour-matrix coefficients for the
// RGB-to-YUV encoder that mirrors the Milestone 1 decoder.
package m1e_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_RD4,
    S_RD5,
    S_WAIT0,
    S_WAIT1,
    S_WR_Y0,
    S_WR_Y1,
    S_WR_U,
    S_WR_V
  } m1e_state_t;

  localparam logic [17:0] Y_BASE   = 18'd0;
  localparam logic [17:0] U_BASE   = 18'd38400;
  localparam logic [17:0] V_BASE   = 18'd57600;
  localparam logic [17:0] RGB_BASE = 18'd146944;

  localparam int COEF_YR = 66;
  localparam int COEF_YG = 129;
  localparam int COEF_YB = 25;
  localparam int COEF_UR = -38;
  localparam int COEF_UG = -74;
  localparam int COEF_UB = 112;
  localparam int COEF_VR = 112;
  localparam int COEF_VG = -94;
  localparam int COEF_VB = -18;

  function automatic logic [7:0] clip8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

endpackage

// File: rtl/yuv_pixel_matrix.sv
// yuv_pixel_matrix: combinational colour matrix producing the signed partial
// sums for one pixel; chroma sums are tied to zero when CHROMA_EN is clear.
module yuv_pixel_matrix
  import m1e_pkg::*;
#(
  parameter bit CHROMA_EN = 1'b1
) (
  input  logic [7:0]         r,
  input  logic [7:0]         g,
  input  logic [7:0]         b,
  output logic signed [31:0] s_y,
  output logic signed [31:0] s_u,
  output logic signed [31:0] s_v
);

  logic signed [31:0] ri, gi, bi;

  assign ri = {24'd0, r};
  assign gi = {24'd0, g};
  assign bi = {24'd0, b};

  assign s_y = COEF_YR * ri + COEF_YG * gi + COEF_YB * bi;

  generate
    if (CHROMA_EN) begin : g_chroma
      assign s_u = COEF_UR * ri + COEF_UG * gi + COEF_UB * bi;
      assign s_v = COEF_VR * ri + COEF_VG * gi + COEF_VB * bi;
    end else begin : g_no_chroma
      assign s_u = '0;
      assign s_v = '0;
    end
  endgenerate

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// rgb_to_yuv_encoder: reads packed RGB pairs from SRAM and writes the Y/U/V planes
// in the decoder's layout. Define UV_AVG_EN to average chroma over each pixel pair.
module rgb_to_yuv_encoder
  import m1e_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        M1E_start,
  output logic        M1E_done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam int GROUPS = IMG_W * IMG_H / 4;
  localparam logic [17:0] LAST_GROUP = 18'(GROUPS - 1);
`ifdef UV_AVG_EN
  localparam bit ODD_CHROMA = 1'b1;
`else
  localparam bit ODD_CHROMA = 1'b0;
`endif

  m1e_state_t state;
  logic [17:0] y_addr, u_addr, v_addr, rgb_addr, group_cnt;
  logic [15:0] rgb_word [6];
  logic [7:0]  u0_q, v0_q, u1_q, v1_q;

  logic [15:0] pw0, pw1, pw2;
  logic signed [31:0] sy_e, su_e, sv_e, sy_o, su_o, sv_o;
  logic [7:0]  y_e, y_o, u_pair, v_pair;

  // Pair 0 is converted on the way out of S_WAIT1, pair 1 during S_WR_Y0.
  always_comb begin
    pw0 = rgb_word[0];
    pw1 = rgb_word[1];
    pw2 = rgb_word[2];
    if (state == S_WR_Y0) begin
      pw0 = rgb_word[3];
      pw1 = rgb_word[4];
      pw2 = rgb_word[5];
    end
  end

  yuv_pixel_matrix #(.CHROMA_EN(1'b1)) u_even (
    .r   (pw0[15:8]),
    .g   (pw0[7:0]),
    .b   (pw1[15:8]),
    .s_y (sy_e),
    .s_u (su_e),
    .s_v (sv_e)
  );

  yuv_pixel_matrix #(.CHROMA_EN(ODD_CHROMA)) u_odd (
    .r   (pw1[7:0]),
    .g   (pw2[15:8]),
    .b   (pw2[7:0]),
    .s_y (sy_o),
    .s_u (su_o),
    .s_v (sv_o)
  );

  assign y_e = clip8(16 + ((sy_e + 128) >>> 8));
  assign y_o = clip8(16 + ((sy_o + 128) >>> 8));

`ifdef UV_AVG_EN
  assign u_pair = clip8(128 + ((su_e + su_o + 256) >>> 9));
  assign v_pair = clip8(128 + ((sv_e + sv_o + 256) >>> 9));
`else
  logic unused_odd_chroma;
  assign unused_odd_chroma = ^{su_o, sv_o};
  assign u_pair = clip8(128 + ((su_e + 128) >>> 8));
  assign v_pair = clip8(128 + ((sv_e + 128) >>> 8));
`endif

  // Read address for S_RDk is registered on entry, so data lands two states later.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      M1E_done        <= 1'b0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      y_addr          <= Y_BASE;
      u_addr          <= U_BASE;
      v_addr          <= V_BASE;
      rgb_addr        <= RGB_BASE;
      group_cnt       <= '0;
      u0_q            <= '0;
      v0_q            <= '0;
      u1_q            <= '0;
      v1_q            <= '0;
      for (int i = 0; i < 6; i++) rgb_word[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          SRAM_we_n <= 1'b1;
          if (M1E_start) begin
            M1E_done     <= 1'b0;
            y_addr       <= Y_BASE;
            u_addr       <= U_BASE;
            v_addr       <= V_BASE;
            SRAM_address <= RGB_BASE;
            rgb_addr     <= RGB_BASE + 18'd1;
            group_cnt    <= '0;
            state        <= S_RD0;
          end
        end
        S_RD0, S_RD1, S_RD2, S_RD3, S_RD4: begin
          SRAM_address <= rgb_addr;
          rgb_addr     <= rgb_addr + 18'd1;
          if (state == S_RD2) rgb_word[0] <= SRAM_read_data;
          if (state == S_RD3) rgb_word[1] <= SRAM_read_data;
          if (state == S_RD4) rgb_word[2] <= SRAM_read_data;
          state <= m1e_state_t'(state + 4'd1);
        end
        S_RD5: begin
          rgb_word[3] <= SRAM_read_data;
          state       <= S_WAIT0;
        end
        S_WAIT0: begin
          rgb_word[4] <= SRAM_read_data;
          state       <= S_WAIT1;
        end
        S_WAIT1: begin
          rgb_word[5]     <= SRAM_read_data;
          SRAM_address    <= y_addr;
          SRAM_write_data <= {y_e, y_o};
          SRAM_we_n       <= 1'b0;
          u0_q            <= u_pair;
          v0_q            <= v_pair;
          state           <= S_WR_Y0;
        end
        S_WR_Y0: begin
          SRAM_address    <= y_addr + 18'd1;
          SRAM_write_data <= {y_e, y_o};
          u1_q            <= u_pair;
          v1_q            <= v_pair;
          y_addr          <= y_addr + 18'd2;
          state           <= S_WR_Y1;
        end
        S_WR_Y1: begin
          SRAM_address    <= u_addr;
          SRAM_write_data <= {u0_q, u1_q};
          u_addr          <= u_addr + 18'd1;
          state           <= S_WR_U;
        end
        S_WR_U: begin
          SRAM_address    <= v_addr;
          SRAM_write_data <= {v0_q, v1_q};
          v_addr          <= v_addr + 18'd1;
          state           <= S_WR_V;
        end
        S_WR_V: begin
          SRAM_we_n <= 1'b1;
          if (group_cnt == LAST_GROUP) begin
            M1E_done <= 1'b1;
            state    <= S_IDLE;
          end else begin
            group_cnt    <= group_cnt + 18'd1;
            SRAM_address <= rgb_addr;
            rgb_addr     <= rgb_addr + 18'd1;
            state        <= S_RD0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
